// File: rtl/bp_nonsynth_mem_mux_pkg.sv
// Shared helpers for the nonsynth memory-command multiplexer.
// Messages stay packed bp_cce_mem_msg_s vectors; the instantiator casts them.
package bp_nonsynth_mem_mux_pkg;

  localparam int max_ch_c = 16;

  // Channel-id width: $clog2(num_ch) with a minimum of 1 bit.
  function automatic int ch_id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/bp_nonsynth_mem_mux_tag_fifo.sv
// In-order channel-id FIFO recording which channel issued each in-flight command.
// Push and pop may occur in the same cycle; the caller never pushes when full or pops when empty.
module bp_nonsynth_mem_mux_tag_fifo
  import bp_nonsynth_mem_mux_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         push_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         pop_i,
  output logic [width_p-1:0]           head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      // els_p is a power of 2, so pointer overflow is the modulo wrap.
      if (push_i) wptr_r <= wptr_r + ptr_w_lp'(1);
      if (pop_i)  rptr_r <= rptr_r + ptr_w_lp'(1);
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wptr_r] <= data_i;
  end

  assign head_o  = mem_r[rptr_r];
  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign count_o = count_r;

endmodule

// File: rtl/bp_nonsynth_mem_mux.sv
// N-channel mem_cmd multiplexer onto one in-order bp_mem port, routing each mem_resp
// back to its issuing channel, with sticky watchdog and unexpected-response flags.
module bp_nonsynth_mem_mux
  import bp_nonsynth_mem_mux_pkg::*;
#(
  parameter int num_ch_p          = 2,
  parameter int msg_width_p       = 512,
  parameter int outstanding_els_p = 4,
  parameter int timeout_cycles_p  = 100000
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_ch_p*msg_width_p-1:0]      ch_cmd_i,
  input  logic [num_ch_p-1:0]                  ch_cmd_v_i,
  output logic [num_ch_p-1:0]                  ch_cmd_ready_o,
  output logic [num_ch_p*msg_width_p-1:0]      ch_resp_o,
  output logic [num_ch_p-1:0]                  ch_resp_v_o,
  input  logic [num_ch_p-1:0]                  ch_resp_yumi_i,
  output logic [msg_width_p-1:0]               mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]               mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o,
  output logic [$clog2(outstanding_els_p+1)-1:0] outstanding_o,
  output logic                                 timeout_o,
  output logic                                 unexp_resp_o
);

  // Handshakes: a command transfers on a cycle where valid and ready are both high;
  // a response transfers on a cycle where valid and yumi are both high (yumi implies valid).

  localparam int ch_id_w_lp = ch_id_width(num_ch_p);
  localparam int cnt_w_lp   = $clog2(outstanding_els_p+1);
  localparam int wd_w_lp    = $clog2(timeout_cycles_p+1);

  logic [ch_id_w_lp-1:0] rr_ptr_r, grant_id, head_id;
  logic                  grant_v, fifo_full, fifo_empty, accept, pop, resp_live;
  logic [cnt_w_lp-1:0]   count;
  logic [wd_w_lp-1:0]    wd_r, wd_next;
  logic                  timeout_r, unexp_r;
  int                    idx;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = num_ch_p - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_r) + k) % num_ch_p;
      if (ch_cmd_v_i[idx]) begin
        grant_v  = 1'b1;
        grant_id = ch_id_w_lp'(idx);
      end
    end
  end

  assign mem_cmd_v_o = reset_n_i & grant_v & ~fifo_full;
  assign mem_cmd_o   = ch_cmd_i[int'(grant_id)*msg_width_p +: msg_width_p];
  assign accept      = mem_cmd_v_o & mem_cmd_ready_i;
  assign resp_live   = reset_n_i & ~fifo_empty & mem_resp_v_i;
  assign pop         = mem_resp_yumi_o;
  assign ch_resp_o   = {num_ch_p{mem_resp_i}};

  always_comb begin
    ch_cmd_ready_o  = '0;
    ch_resp_v_o     = '0;
    mem_resp_yumi_o = 1'b0;
    for (int i = 0; i < num_ch_p; i++) begin
      ch_cmd_ready_o[i] = accept & (grant_id == ch_id_w_lp'(i));
      ch_resp_v_o[i]    = resp_live & (head_id == ch_id_w_lp'(i));
      mem_resp_yumi_o   = mem_resp_yumi_o | (ch_resp_v_o[i] & ch_resp_yumi_i[i]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= '0;
    end else if (accept) begin
      rr_ptr_r <= (grant_id == ch_id_w_lp'(num_ch_p - 1)) ? '0 : grant_id + ch_id_w_lp'(1);
    end
  end

  bp_nonsynth_mem_mux_tag_fifo #(
    .els_p   (outstanding_els_p),
    .width_p (ch_id_w_lp)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (accept),
    .data_i    (grant_id),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  assign outstanding_o = count;

  // Watchdog counts stalled cycles and saturates once it reaches the limit.
  always_comb begin
    wd_next = wd_r;
    if (pop || (count == '0))                         wd_next = '0;
    else if (wd_r != wd_w_lp'(timeout_cycles_p))      wd_next = wd_r + wd_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
      unexp_r   <= 1'b0;
    end else begin
      wd_r      <= wd_next;
      timeout_r <= timeout_r | (wd_next == wd_w_lp'(timeout_cycles_p));
      unexp_r   <= unexp_r | (fifo_empty & mem_resp_v_i);
    end
  end

  assign timeout_o    = timeout_r;
  assign unexp_resp_o = unexp_r;

endmodule

// File: tb/tb_bp_nonsynth_mem_mux.sv
// Bench for bp_nonsynth_mem_mux: directed boundary sequences plus random traffic,
// every cycle compared against a queue-based model of arbitration and in-order routing.
module tb_bp_nonsynth_mem_mux;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int TMO = 10;
  localparam int CW  = $clog2(ELS+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] ch_cmd, ch_resp;
  logic [N-1:0]   ch_cmd_v, ch_cmd_ready, ch_resp_v, ch_resp_yumi;
  logic [W-1:0]   mem_cmd, mem_resp;
  logic           mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi;
  logic [CW-1:0]  outstanding;
  logic           timeout, unexp_resp;

  bp_nonsynth_mem_mux #(
    .num_ch_p(N), .msg_width_p(W), .outstanding_els_p(ELS), .timeout_cycles_p(TMO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .ch_cmd_i(ch_cmd), .ch_cmd_v_i(ch_cmd_v), .ch_cmd_ready_o(ch_cmd_ready),
    .ch_resp_o(ch_resp), .ch_resp_v_o(ch_resp_v), .ch_resp_yumi_i(ch_resp_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
    .outstanding_o(outstanding), .timeout_o(timeout), .unexp_resp_o(unexp_resp)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]   exp_q[$];   // issuing channel of each in-flight command, oldest first
  logic [W-1:0] mem_q[$];   // command payloads held by the bench memory
  int rr = 0;
  int wd = 0;
  bit exp_tmo = 0;
  bit exp_unexp = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int grant_of();
    for (int k = 0; k < N; k++) begin
      if (ch_cmd_v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    mem_q.delete();
    rr = 0; wd = 0; exp_tmo = 0; exp_unexp = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ch_cmd        = {$urandom, $urandom};
    ch_cmd_v      = '0;
    mem_cmd_ready = 1'b0;
    mem_resp_v    = 1'b0;
    ch_resp_yumi  = '0;
    mem_resp      = W'($urandom);
  endtask

  task automatic drive_resp();
    if (mem_q.size() > 0) mem_resp = mem_q[0] ^ 16'hA5A5;
    else                  mem_resp = W'($urandom);
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step();
    int g;
    bit full, exp_v, acc, pop, busy, unexp_evt;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [W-1:0] g_data;
    #1;
    full  = (exp_q.size() == ELS);
    g     = grant_of();
    exp_v = (g >= 0) && !full;
    acc   = exp_v && mem_cmd_ready;
    g_data = (g >= 0) ? ch_cmd[g*W +: W] : '0;
    exp_rdy = acc ? N'(1 << g) : '0;
    busy  = (exp_q.size() > 0);
    exp_rv = (busy && mem_resp_v) ? N'(1 << exp_q[0]) : '0;
    pop   = busy && mem_resp_v && ch_resp_yumi[exp_q[0]];
    unexp_evt = !busy && mem_resp_v;
    check("mem_cmd_v", mem_cmd_v, exp_v);
    if (exp_v) check("mem_cmd", mem_cmd, g_data);
    check("cmd_ready", ch_cmd_ready, exp_rdy);
    check("resp_v", ch_resp_v, exp_rv);
    check("resp_yumi", mem_resp_yumi, pop);
    check("resp_data", ch_resp[(N-1)*W +: W], mem_resp);
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      void'(mem_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(2'(g));
      mem_q.push_back(g_data);
      rr = (g + 1) % N;
    end
    if (busy && !pop) begin
      if (wd < TMO) wd++;
    end else begin
      wd = 0;
    end
    if (wd == TMO) exp_tmo = 1;
    if (unexp_evt) exp_unexp = 1;
    #1;
    check("outstanding", outstanding, exp_q.size());
    check("timeout", timeout, exp_tmo);
    check("unexp", unexp_resp, exp_unexp);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ch_cmd_v = '1; mem_cmd_ready = 1'b1; mem_resp_v = 1'b1; ch_resp_yumi = '1;
    #1;
    check("rst_cmd_v", mem_cmd_v, 0);
    check("rst_ready", ch_cmd_ready, 0);
    check("rst_resp_v", ch_resp_v, 0);
    check("rst_yumi", mem_resp_yumi, 0);
    check("rst_outst", outstanding, 0);
    check("rst_tmo", timeout, 0);
    check("rst_unexp", unexp_resp, 0);
    model_clear();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      idle_inputs();
      mem_resp_v = 1'b1;
      ch_resp_yumi = '1;
      drive_resp();
      step();
    end
    check("drained", outstanding, 0);
  endtask

  task automatic rand_cycle();
    ch_cmd        = {$urandom, $urandom};
    ch_cmd_v      = N'($urandom_range(0, (1 << N) - 1));
    mem_cmd_ready = ($urandom_range(0, 3) != 0);
    mem_resp_v    = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
    ch_resp_yumi  = N'($urandom_range(0, (1 << N) - 1));
    drive_resp();
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    #1;
    apply_reset();

    // Round-robin between two always-valid channels.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      ch_cmd_v = 3'b011;
      mem_cmd_ready = 1'b1;
      #1 check("rr_grant", ch_cmd_ready, (i % 2) ? 3'b010 : 3'b001);
      step();
    end
    check("rr_peak", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      mem_resp_v = 1'b1;
      ch_resp_yumi = '1;
      drive_resp();
      #1 check("rr_resp", ch_resp_v, (i % 2) ? 3'b010 : 3'b001);
      step();
    end

    // Fill to capacity from ch0; the fifth command is held.
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ch_cmd_v = 3'b001;
      mem_cmd_ready = 1'b1;
      step();
    end
    idle_inputs();
    ch_cmd_v = 3'b001;
    mem_cmd_ready = 1'b1;
    #1;
    check("full_rdy", ch_cmd_ready, 0);
    check("full_cnt", outstanding, 4);
    step();
    // Yumi on non-head channels is ignored.
    idle_inputs();
    mem_resp_v = 1'b1;
    ch_resp_yumi = 3'b110;
    drive_resp();
    step();
    check("nonhead_yumi", outstanding, 4);
    // Pop while full with a push attempt: push blocked this cycle, taken next.
    idle_inputs();
    ch_cmd_v = 3'b001; mem_cmd_ready = 1'b1;
    mem_resp_v = 1'b1; ch_resp_yumi = 3'b001;
    drive_resp();
    step();
    check("pp_cnt", outstanding, 3);
    idle_inputs();
    ch_cmd_v = 3'b001; mem_cmd_ready = 1'b1;
    step();
    check("pp_refill", outstanding, 4);
    drain();

    // Response with nothing outstanding.
    idle_inputs();
    mem_resp_v = 1'b1;
    ch_resp_yumi = '1;
    #1;
    check("unexp_yumi", mem_resp_yumi, 0);
    check("unexp_resp_v", ch_resp_v, 0);
    check("unexp_pre", unexp_resp, 0);
    step();
    check("unexp_set", unexp_resp, 1);
    idle_inputs();
    step();
    step();
    check("unexp_held", unexp_resp, 1);

    // Watchdog: one command, no response.
    apply_reset();
    idle_inputs();
    ch_cmd_v = 3'b010; mem_cmd_ready = 1'b1;
    step();
    for (int i = 1; i <= 12; i++) begin
      idle_inputs();
      step();
      check("tmo_lat", timeout, (i >= TMO));
    end
    drain();
    check("tmo_held", timeout, 1);

    // Asynchronous reset with three outstanding.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ch_cmd_v = 3'b110; mem_cmd_ready = 1'b1;
      step();
    end
    check("pre_rst_cnt", outstanding, 3);
    idle_inputs();
    ch_cmd_v = '1; mem_cmd_ready = 1'b1; mem_resp_v = 1'b1; ch_resp_yumi = '1;
    #3 reset_n = 1'b0;
    #1;
    check("arst_cmd_v", mem_cmd_v, 0);
    check("arst_ready", ch_cmd_ready, 0);
    check("arst_resp_v", ch_resp_v, 0);
    check("arst_yumi", mem_resp_yumi, 0);
    check("arst_outst", outstanding, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    ch_cmd_v = '1;
    #1 check("post_rst_grant", ch_cmd_ready, 3'b001);
    step();

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 2000; i++) begin
      if (i % 700 == 699) apply_reset();
      else rand_cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_mem_mux.md
Name: bp_nonsynth_mem_mux

Overview:
- Parametrised N-channel memory-command multiplexer for multicore nonsynth testbenches.
- Arbitrates num_ch_p processor mem_cmd streams onto a single bp_mem port and routes mem_resp back to the issuing channel.
- Tracks outstanding requests in an in-order tag FIFO, since bp_mem responds in order.
- Flags stalled or unexpected responses with a watchdog, generalising the single-core direct proc-to-mem hookup.

Parameters:
- num_ch_p, 2, number of processor channels (1..16).
- msg_width_p, 512, width of a packed bp_cce_mem_msg_s.
- outstanding_els_p, 4, max in-flight commands across all channels (power of 2, ≥2).
- timeout_cycles_p, 100000, cycles without a response while outstanding before timeout_o asserts.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- ch_cmd_i  in  num_ch_p*msg_width_p  per-channel commands, channel i at slice i.
- ch_cmd_v_i  in  num_ch_p  per-channel command valid.
- ch_cmd_ready_o  out  num_ch_p  per-channel command accept (valid-and-ready handshake).
- ch_resp_o  out  num_ch_p*msg_width_p  per-channel responses; every slice carries mem_resp_i.
- ch_resp_v_o  out  num_ch_p  per-channel response valid.
- ch_resp_yumi_i  in  num_ch_p  per-channel response consume.
- mem_cmd_o  out  msg_width_p  selected command.
- mem_cmd_v_o  out  1  command valid to memory.
- mem_cmd_ready_i  in  1  memory ready.
- mem_resp_i  in  msg_width_p  memory response.
- mem_resp_v_i  in  1  memory response valid.
- mem_resp_yumi_o  out  1  memory response consume.
- outstanding_o  out  $clog2(outstanding_els_p+1)  in-flight count.
- timeout_o  out  1  sticky watchdog flag.
- unexp_resp_o  out  1  sticky flag: response arrived with nothing outstanding.

Behaviour:
- Reset:
  - Asynchronous assertion clears the RR pointer to 0, the tag FIFO (rptr, wptr, count), the watchdog counter, timeout_o and unexp_resp_o.
  - All ready, valid and yumi outputs read 0 while reset_n_i is low.
  - Any in-flight traffic is discarded; the bench must reset memory together with the mux.
- Arbitration:
  - Round-robin starting at rr_ptr; grant goes to the first i with ch_cmd_v_i[i], searching rr_ptr, rr_ptr+1, … mod num_ch_p.
  - mem_cmd_v_o = |ch_cmd_v_i & ~fifo_full.
  - mem_cmd_o = slice of the granted channel.
  - ch_cmd_ready_o[i] = grant[i] & mem_cmd_ready_i & ~fifo_full.
  - Grant is combinational, with no added latency.
- Accept (mem_cmd_v_o & mem_cmd_ready_i):
  - Push the granted channel id into the tag FIFO.
  - rr_ptr ← (granted id + 1) mod num_ch_p.
  - With no accept, rr_ptr holds, so a stalled grant is stable while mem_cmd_ready_i is low.
- Response routing:
  - With the FIFO non-empty, head = FIFO[rptr].
  - ch_resp_v_o[head] = mem_resp_v_i; all other bits are 0.
  - mem_resp_yumi_o = ch_resp_yumi_i[head].
  - The FIFO pops on mem_resp_yumi_o.
  - yumi on a non-head channel is ignored.
- Empty FIFO with mem_resp_v_i:
  - All ch_resp_v_o = 0 and mem_resp_yumi_o = 0.
  - unexp_resp_o sets the next cycle and stays set until reset.
- FIFO boundaries:
  - Full (count == outstanding_els_p) blocks all commands.
  - Push and pop in the same cycle are legal at any count, including full; a full FIFO still blocks a push that cycle because ready was computed pre-pop.
  - Count is unchanged on simultaneous push and pop.
  - Pointers wrap modulo outstanding_els_p.
- outstanding_o = count, registered.
- Watchdog:
  - The counter increments each cycle with count ≠ 0 and no pop.
  - It clears on a pop or when count == 0.
  - When the counter reaches timeout_cycles_p, timeout_o sets and stays sticky; the counter saturates.
- num_ch_p == 1 degenerates to a passthrough plus tracking; the grant is always channel 0.

Decomposition:
- bp_me_pkg additions: localparam for ch-id width, $clog2(num_ch_p) with a minimum of 1.
- No new typedefs; messages stay packed bp_cce_mem_msg_s, cast by the instantiator.
- One sub-module: bp_nonsynth_mem_mux_tag_fifo, a parametrised in-order id FIFO with count output and simultaneous push/pop.
- The round-robin arbiter stays inline.

Test Plan:
- num_ch_p=2, both channels hold v for 4 commands, mem ready always → accepts ordered ch0, ch1, ch0, ch1; responses return to ch0, ch1, ch0, ch1; outstanding_o peaks ≤4.
- outstanding_els_p=4, ch0 issues 5 commands with responses stalled → 4 accepted, 5th held with ch_cmd_ready_o[0]=0 and outstanding_o=4; one yumi → 5th accepted the following cycle.
- Full FIFO with push attempt and pop in the same cycle → pop occurs, push blocked, count 4→3; the next cycle push accepted, count 3→4.
- mem_resp_v_i pulsed with the FIFO empty → mem_resp_yumi_o=0, all ch_resp_v_o=0, unexp_resp_o=1 one cycle later and held.
- timeout_cycles_p=10, one command issued, no response → timeout_o=1 exactly 10 cycles after accept, held after the response arrives.
- reset_n_i dropped mid-cycle with 3 outstanding → outputs 0 immediately (asynchronous), outstanding_o=0, rr_ptr=0; after release, first arbitration favours ch0.
